// File: rtl/mux_rr_reg.sv
// N:1 registered multiplexer with valid/ready handshake.
// Fixed-select or round-robin arbitration feeds one output register stage.
module mux_rr_reg #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*WIDTH-1:0]  in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   modo,
  input  logic [SELW-1:0]        sel,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [N_CH-1:0][WIDTH-1:0] ch_data;
  logic [SELW-1:0]            ptr;
  logic [SELW-1:0]            gnt;
  logic                       gnt_vld;
  logic                       ld;

  assign ch_data = in_data;
  assign ld      = !out_valid || out_ready;

  // Round-robin scan runs from the far end back so the lowest offset past ptr wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    if (!modo) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(i);
        end
      end
    end else begin
      for (int k = N_CH; k >= 1; k--) begin
        j = int'(ptr) + k;
        if (j >= N_CH) j = j - N_CH;
        if (in_valid[j]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(j);
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_rdy
    assign in_ready[i] = ld && gnt_vld && (gnt == SELW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(N_CH - 1);
    end else if (ld) begin
      if (gnt_vld) begin
        out_data  <= ch_data[gnt];
        out_ch    <= gnt;
        out_valid <= 1'b1;
        if (modo) ptr <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Randomized and directed bench for mux_rr_reg against a queue-free behavioural model.
module tb_mux_rr_reg;
  localparam int WIDTH = 8;
  localparam int N_CH  = 4;
  localparam int SELW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  modo;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;

  int checks = 0;
  int errors = 0;

  // model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_ptr;

  mux_rr_reg #(.WIDTH(WIDTH), .N_CH(N_CH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .modo(modo), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // -1 means no channel granted
  function automatic int exp_gnt(logic md, logic [SELW-1:0] s, logic [N_CH-1:0] v, int p);
    if (!md) return (int'(s) < N_CH && v[s]) ? int'(s) : -1;
    for (int k = 1; k <= N_CH; k++)
      if (v[(p + k) % N_CH]) return (p + k) % N_CH;
    return -1;
  endfunction

  function automatic logic [N_CH-1:0] exp_rdy();
    logic [N_CH-1:0] r;
    int g;
    r = '0;
    g = exp_gnt(modo, sel, in_valid, m_ptr);
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = N_CH - 1;
  endtask

  // Advance one clock; the model follows the handshake rules using pre-edge inputs.
  task automatic tick();
    int g;
    logic ld;
    g  = exp_gnt(modo, sel, in_valid, m_ptr);
    ld = !m_valid || out_ready;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_ch    = g;
        m_valid = 1'b1;
        if (modo) m_ptr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_valid = '0; modo = 1'b0; sel = '0; out_ready = 1'b1;
    model_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++; if (out_ch !== '0) begin errors++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL reset_rdy got %b want 0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    modo = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data[1*WIDTH +: WIDTH] = 8'hA5; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_rdy got %b want 0010", in_ready); end
    tick();
    checks++;
    if (out_data !== 8'hA5 || out_ch !== 2'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL fixed_out got %h/%0d/%b want a5/1/1", out_data, out_ch, out_valid);
    end
    sel = 2'd2;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nogrant_rdy got %b want 0000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      errors++; $display("FAIL fixed_drain got %b/%h want 0/a5", out_valid, out_data);
    end
  endtask

  task automatic test_rr_all();
    pulse_reset();
    modo = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_ch) != c % N_CH || out_data !== in_data[(c % N_CH)*WIDTH +: WIDTH]) begin
        errors++; $display("FAIL rr_all[%0d] got %b/%0d/%h want 1/%0d/%h", c, out_valid, out_ch, out_data,
                           c % N_CH, in_data[(c % N_CH)*WIDTH +: WIDTH]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int seq [3] = '{3, 1, 3};
    modo = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
    tick();  // moves the pointer to 1
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (int'(out_ch) != seq[c] || out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_sparse[%0d] got ch %0d want %0d", c, out_ch, seq[c]);
      end
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] first, second;
    first = 8'h3C; second = 8'hC3;
    modo = 1'b0; sel = '0; in_valid = 4'b0001; in_data[0 +: WIDTH] = first; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data[0 +: WIDTH] = second;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL stall_rdy[%0d] got %b want 0000", c, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== first) begin
        errors++; $display("FAIL stall_hold[%0d] got %b/%h want 1/%h", c, out_valid, out_data, first);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_rdy got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== second) begin
      errors++; $display("FAIL stall_nobubble got %b/%h want 1/%h", out_valid, out_data, second);
    end
  endtask

  task automatic test_reset_mid();
    modo = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got %b want 0", out_valid); end
    model_reset();
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_mid_rdy got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_ch !== '0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_first got %0d/%b want 0/1", out_ch, out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      modo      = 1'($urandom);
      sel       = SELW'($urandom);
      in_valid  = N_CH'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== exp_rdy()) begin
        errors++; $display("FAIL rand_rdy[%0d] got %b want %b", c, in_ready, exp_rdy());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch) begin
        errors++; $display("FAIL rand_out[%0d] got %b/%h/%0d want %b/%h/%0d", c, out_valid, out_data,
                           out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
